// File: rtl/fifo_bridge.sv
// Transfer engine between two FIFO stages: pops the upstream head into a one-entry
// staging register and pushes it downstream, sustaining one word per cycle.
module fifo_bridge #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 up_empty,
    input  logic [WIDTH-1:0]     up_data,
    output logic                 up_pop,
    input  logic                 dn_full,
    output logic                 dn_push,
    output logic [WIDTH-1:0]     dn_data,
    output logic                 hold_vld,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] xfer_count,
    output logic [1:0]           state_dbg
);

    // Handshake: a word leaves the upstream FIFO on an edge where up_pop is high
    // (never while up_empty), and enters the downstream FIFO on an edge where
    // dn_push is high (never while dn_full); both are purely combinational.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     hreg;
    logic                 session_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && !stop) state_nxt = S_RUN;
            S_RUN:   if (stop) state_nxt = S_DRAIN;
            // Leave once nothing is held, or the last held word is leaving now.
            S_DRAIN: if (!hold_vld || dn_push) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dn_push       = hold_vld && !dn_full;
        up_pop        = (state == S_RUN) && !up_empty && (!hold_vld || dn_push);
        busy          = (state != S_IDLE);
        session_start = (state == S_IDLE) && start && !stop;
        state_dbg     = state;
    end

    // A pop refills the register even when the old word is being pushed this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hreg     <= '0;
            hold_vld <= 1'b0;
        end else if (up_pop) begin
            hreg     <= up_data;
            hold_vld <= 1'b1;
        end else if (dn_push) begin
            hold_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || session_start) begin
            xfer_count <= '0;
        end else if (dn_push) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end

    assign dn_data = hreg;

endmodule

// File: doc/fifo_bridge.md
# fifo_bridge

Active transfer engine that links two FIFO stages in the composed FIFO chain. It acts as the reader of an upstream FIFO and the writer of a downstream FIFO. It pops words from the upstream stage, holds each in a one-entry staging register, and pushes it downstream, respecting the upstream empty and downstream full flags. The design sustains one word per cycle, preserves order, and drains cleanly on a stop request so both scoreboards see a loss-free, duplicate-free stream.

## Interface
- WIDTH, default 8: data word width; matches the FIFO data width.
- CNT_WIDTH, default 8: width of the transfer counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; in IDLE, begins a transfer session.
- stop  in  1  level; in RUN, requests a drain and end of session. Has priority over start.
- up_empty  in  1  upstream FIFO empty flag.
- up_data  in  WIDTH  upstream head word. First-word-fall-through: valid whenever !up_empty.
- up_pop  out  1  upstream pop; the head is consumed at the clock edge.
- dn_full  in  1  downstream FIFO full flag.
- dn_push  out  1  downstream push; dn_data is captured at the clock edge.
- dn_data  out  WIDTH  staging register contents.
- hold_vld  out  1  staging register holds an unsent word.
- busy  out  1  state != IDLE.
- xfer_count  out  CNT_WIDTH  number of dn_push cycles in the current session.

## Operation
States:
- IDLE (reset state): no pops. IDLE->RUN when start && !stop.
- RUN: pops are enabled. RUN->DRAIN when stop.
- DRAIN: no pops. DRAIN->IDLE on the first cycle where !hold_vld, or where hold_vld && dn_push.

Combinational outputs:
- dn_push = hold_vld && !dn_full.
- up_pop = (state==RUN) && !up_empty && (!hold_vld || dn_push).
- dn_push and up_pop never assert against a full or empty flag.

Staging register update at each edge:
- If up_pop: hreg <= up_data and hold_vld <= 1. This covers a simultaneous push and pop: the register is refilled and hold_vld stays 1.
- Else if dn_push: hold_vld <= 0 and hreg keeps its value.
- Else: hreg and hold_vld are unchanged.

Transfer counter:
- Increments by 1 on every dn_push.
- Wraps modulo 2^CNT_WIDTH with no saturation flag.
- Cleared to 0 on the IDLE->RUN transition.
- If dn_push happens in the same cycle as that transition, which cannot occur because hold_vld is 0 in IDLE, the clear wins.

Invariants (checked with formal properties in FORMAL builds):
- hold_vld==0 whenever state==IDLE.
- up_pop implies state==RUN.
- Words leave in the exact order they were popped; none are lost or duplicated.
- busy is low only in IDLE.

Boundary behaviour:
- Downstream full while holding: hreg is held stable and no pop occurs until dn_full deasserts.
- Upstream empty: no pop. hold_vld drains normally.
- stop and start asserted together in IDLE: the block stays IDLE.
- start in RUN or DRAIN: ignored.
- Reset mid-transfer: the held word is discarded and the session is aborted. The environment resets the FIFOs together with the bridge.

## Timing
- Reset values: state IDLE, hold_vld 0, hreg 0, xfer_count 0. Outputs: up_pop 0, dn_push 0, dn_data 0, busy 0.
- Latency: a word popped at edge t can be pushed downstream at edge t+1, giving a pop-to-push latency of 1 cycle.
- Throughput: 1 word per cycle in steady state (up_empty=0, dn_full=0).
- First pop: the first edge after the IDLE->RUN transition. start sampled at edge t puts the block in RUN at t+1, so up_pop can be high during cycle t+1.
- Drain: completes at most 1 cycle after dn_full deasserts. busy falls on the edge after the last dn_push.

## Test plan
- Reset, then start=1 for one cycle with upstream holding 0xA1,0xA2,0xA3 and dn_full=0 -> pops on 3 consecutive cycles; dn_data 0xA1,0xA2,0xA3 pushed on the following 3 cycles; xfer_count=3.
- Steady stream, then dn_full=1 for 4 cycles with hreg=0x55 -> up_pop=0 and dn_data=0x55 stable for all 4 cycles; the push occurs the cycle dn_full drops, with a concurrent pop.
- In RUN with hold_vld=1 and dn_full=1, assert stop -> DRAIN with no pops; when dn_full falls, one push occurs and the block goes IDLE with busy=0 on the next edge.
- start and stop asserted together in IDLE -> state stays IDLE, up_pop=0, xfer_count unchanged.
- CNT_WIDTH=4, 17 words transferred -> xfer_count reads 1 (wrapped); a new session start clears it to 0.
- rst asserted while hold_vld=1 in RUN -> next cycle hold_vld=0, busy=0, dn_push=0, xfer_count=0.
